// File: rtl/enemy_pkg.sv
// Shared types, screen constants and box-overlap helper for enemy logic.
package enemy_pkg;

    typedef enum logic [1:0] {
        WALK_R,
        WALK_L,
        SQUASHED,
        GONE
    } enemy_state_t;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SPR_W    = 16;
    localparam int unsigned SPR_H    = 24;

    // Axis-aligned overlap of two boxes of size w x h; sums are 12-bit so
    // edges near 2047 do not wrap.
    function automatic logic overlap16x24(
        input logic [10:0] ax,
        input logic [10:0] ay,
        input logic [10:0] bx,
        input logic [10:0] by,
        input logic [11:0] w = 12'd16,
        input logic [11:0] h = 12'd24
    );
        logic [11:0] ax_e, ay_e, bx_e, by_e;
        ax_e = {1'b0, ax};
        ay_e = {1'b0, ay};
        bx_e = {1'b0, bx};
        by_e = {1'b0, by};
        return (ax_e < bx_e + w) && (bx_e < ax_e + w) &&
               (ay_e < by_e + h) && (by_e < ay_e + h);
    endfunction

endpackage

// File: rtl/enemy_controller_sprite_hit.sv
// Registered "pixel inside box" test, one Clk of latency.
module sprite_hit #(
    parameter int unsigned W = 16,
    parameter int unsigned H = 24
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [9:0]  i_draw_x,
    input  logic [9:0]  i_draw_y,
    input  logic [10:0] i_x,
    input  logic [10:0] i_y,
    input  logic        i_en,
    output logic        o_hit
);

    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic        r_hit;

    // Unsigned difference also rejects pixels left of / above the box.
    assign w_dx = {1'b0, i_draw_x} - i_x;
    assign w_dy = {1'b0, i_draw_y} - i_y;

    // Register the box test to line up with the registered colour path.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= i_en && (w_dx < 11'(W)) && (w_dy < 11'(H));
        end
    end

    assign o_hit = r_hit;

endmodule

// File: rtl/enemy_controller.sv
// Enemy patrol, stomp/kill collision and sprite flag, updated once per frame.
module enemy_controller
    import enemy_pkg::*;
#(
    parameter logic [10:0] START_X       = 11'd400,
    parameter logic [10:0] MIN_X         = 11'd320,
    parameter logic [10:0] MAX_X         = 11'd560,
    parameter logic [10:0] ENEMY_Y       = 11'd400,
    parameter logic [10:0] STEP          = 11'd1,
    parameter int unsigned SPR_W         = 16,
    parameter int unsigned SPR_H         = 24,
    parameter int unsigned STOMP_BAND    = 4,
    parameter int unsigned SQUASH_FRAMES = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [10:0] characterX,
    input  logic [10:0] characterY,
    input  logic [10:0] progress,
    output logic [10:0] enemy1X,
    output logic [10:0] enemy1Y,
    output logic        enemyDir1,
    output logic        enemy1,
    output logic        dead,
    output logic        stomped
);

    localparam int unsigned CNT_W = (SQUASH_FRAMES > 1) ? $clog2(SQUASH_FRAMES) : 1;

    enemy_state_t     r_state, w_state_nx;
    logic [10:0]      r_wx, w_wx_nx;
    logic [CNT_W-1:0] r_sq_cnt, w_sq_cnt_nx;
    logic             r_dir, w_dir_nx;
    logic             r_dead, w_dead_nx;
    logic             r_stomped, w_stomped_nx;
    logic             r_frame_clk_delayed;

    logic             w_fe;
    logic [10:0]      w_sx;
    logic             w_onscreen;
    logic             w_overlap;
    logic             w_stomp_zone;
    logic             w_at_max;
    logic             w_at_min;

    assign w_fe         = frame_clk & ~r_frame_clk_delayed;
    assign w_sx         = r_wx - progress;
    assign w_onscreen   = (r_wx >= progress) && (w_sx < 11'(SCREEN_W));
    assign w_overlap    = w_onscreen &&
                          overlap16x24(characterX, characterY, w_sx, ENEMY_Y,
                                       12'(SPR_W), 12'(SPR_H));
    assign w_stomp_zone = ({1'b0, characterY} + 12'(SPR_H)) <= ({1'b0, ENEMY_Y} + 12'(STOMP_BAND));
    assign w_at_max     = ({1'b0, r_wx} + {1'b0, STEP}) >= {1'b0, MAX_X};
    assign w_at_min     = {1'b0, r_wx} <= ({1'b0, MIN_X} + {1'b0, STEP});

    // Frame-edge detector and all per-frame state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_clk_delayed <= 1'b0;
            r_state             <= WALK_R;
            r_wx                <= START_X;
            r_sq_cnt            <= '0;
            r_dir               <= 1'b0;
            r_dead              <= 1'b0;
            r_stomped           <= 1'b0;
        end else begin
            r_frame_clk_delayed <= frame_clk;
            r_state             <= w_state_nx;
            r_wx                <= w_wx_nx;
            r_sq_cnt            <= w_sq_cnt_nx;
            r_dir               <= w_dir_nx;
            r_dead              <= w_dead_nx;
            r_stomped           <= w_stomped_nx;
        end
    end

    // Next-state: collision first (stomp freezes movement), then patrol.
    always_comb begin
        w_state_nx   = r_state;
        w_wx_nx      = r_wx;
        w_sq_cnt_nx  = r_sq_cnt;
        w_dir_nx     = r_dir;
        w_dead_nx    = r_dead;
        w_stomped_nx = 1'b0;
        if (w_fe) begin
            unique case (r_state)
                WALK_R, WALK_L: begin
                    if (w_overlap && w_stomp_zone && !r_dead) begin
                        w_state_nx   = SQUASHED;
                        w_sq_cnt_nx  = '0;
                        w_stomped_nx = 1'b1;
                    end else begin
                        if (w_overlap) begin
                            w_dead_nx = 1'b1;
                        end
                        if (r_state == WALK_R) begin
                            if (w_at_max) begin
                                w_wx_nx    = MAX_X;
                                w_state_nx = WALK_L;
                                w_dir_nx   = 1'b1;
                            end else begin
                                w_wx_nx = r_wx + STEP;
                            end
                        end else begin
                            if (w_at_min) begin
                                w_wx_nx    = MIN_X;
                                w_state_nx = WALK_R;
                                w_dir_nx   = 1'b0;
                            end else begin
                                w_wx_nx = r_wx - STEP;
                            end
                        end
                    end
                end
                SQUASHED: begin
                    if (r_sq_cnt == CNT_W'(SQUASH_FRAMES - 1)) begin
                        w_state_nx = GONE;
                    end else begin
                        w_sq_cnt_nx = r_sq_cnt + 1'b1;
                    end
                end
                GONE: begin
                end
                default: begin
                    w_state_nx = WALK_R;
                end
            endcase
        end
    end

    sprite_hit #(
        .W (SPR_W),
        .H (SPR_H)
    ) u_sprite_hit (
        .i_clk    (Clk),
        .i_reset  (Reset),
        .i_draw_x (DrawX),
        .i_draw_y (DrawY),
        .i_x      (w_sx),
        .i_y      (ENEMY_Y),
        .i_en     ((r_state != GONE) && w_onscreen),
        .o_hit    (enemy1)
    );

    assign enemy1X   = w_sx;
    assign enemy1Y   = ENEMY_Y;
    assign enemyDir1 = r_dir;
    assign dead      = r_dead;
    assign stomped   = r_stomped;

endmodule

// File: tb/tb_enemy_controller.sv
// Randomised bench for enemy_controller against a per-frame behavioural model.
module tb_enemy_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [10:0] characterX = '0;
    logic [10:0] characterY = '0;
    logic [10:0] progress = '0;
    logic [10:0] enemy1X;
    logic [10:0] enemy1Y;
    logic        enemyDir1;
    logic        enemy1;
    logic        dead;
    logic        stomped;

    enemy_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .characterX (characterX),
        .characterY (characterY),
        .progress   (progress),
        .enemy1X    (enemy1X),
        .enemy1Y    (enemy1Y),
        .enemyDir1  (enemyDir1),
        .enemy1     (enemy1),
        .dead       (dead),
        .stomped    (stomped)
    );

    always #5 Clk = ~Clk;

    // Reference model: world position, heading, life phase (0 walking,
    // 1 squashed, 2 gone), squash frame count, dead flag, stomp this frame.
    int m_wx, m_dir, m_mode, m_cnt, m_dead, m_stomp;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic bit model_visible();
        int pg;
        pg = int'(progress);
        return (m_mode != 2) && (m_wx >= pg) && (m_wx - pg < 640);
    endfunction

    function automatic int model_sx();
        return (m_wx - int'(progress)) & 2047;
    endfunction

    function automatic bit model_pix(input int dx, input int dy);
        return model_visible() && (((dx - model_sx()) & 2047) < 16) &&
               (((dy - 400) & 2047) < 24);
    endfunction

    task automatic model_reset();
        m_wx = 400; m_dir = 0; m_mode = 0; m_cnt = 0; m_dead = 0; m_stomp = 0;
    endtask

    // One frame of enemy behaviour using the inputs present at the frame edge.
    task automatic model_step();
        int sx, cx, cy;
        bit ov;
        cx = int'(characterX);
        cy = int'(characterY);
        m_stomp = 0;
        if (m_mode == 0) begin
            sx = model_sx();
            ov = model_visible() && (cx < sx + 16) && (sx < cx + 16) &&
                 (cy < 400 + 24) && (400 < cy + 24);
            if (ov && (cy + 24 <= 400 + 4) && (m_dead == 0)) begin
                m_mode = 1; m_cnt = 0; m_stomp = 1;
            end else begin
                if (ov) m_dead = 1;
                if (m_dir == 0) begin
                    if (m_wx + 1 >= 560) begin m_wx = 560; m_dir = 1; end
                    else m_wx = m_wx + 1;
                end else begin
                    if (m_wx <= 320 + 1) begin m_wx = 320; m_dir = 0; end
                    else m_wx = m_wx - 1;
                end
            end
        end else if (m_mode == 1) begin
            if (m_cnt == 29) m_mode = 2;
            else m_cnt = m_cnt + 1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        frame_clk = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        model_reset();
        check("rst_x", enemy1X, (400 - int'(progress)) & 2047);
        check("rst_dir", enemyDir1, 0);
        check("rst_dead", dead, 0);
        check("rst_stomp", stomped, 0);
        check("rst_pix", enemy1, 0);
    endtask

    task automatic frame(input int hold);
        int ex;
        model_step();
        frame_clk = 1'b1;
        tick();
        ex = model_sx();
        check("pos_x", enemy1X, ex);
        check("pos_y", enemy1Y, 400);
        check("dir", enemyDir1, m_dir);
        check("dead", dead, m_dead);
        check("stomp", stomped, m_stomp);
        for (int i = 1; i < hold; i++) begin
            tick();
            check("hold_stomp", stomped, 0);
            check("hold_x", enemy1X, ex);
        end
        frame_clk = 1'b0;
        tick();
        check("stomp_end", stomped, 0);
    endtask

    task automatic pixel(input int dx, input int dy);
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        tick();
        check("pix", enemy1, model_pix(dx & 1023, dy & 1023));
    endtask

    task automatic pixel_near();
        int dx, dy;
        dx = (model_sx() + int'($urandom_range(0, 23)) - 4) & 1023;
        dy = 400 + int'($urandom_range(0, 31)) - 4;
        pixel(dx, dy);
    endtask

    initial begin
        characterX = 11'd0;
        characterY = 11'd0;
        progress   = 11'd0;
        do_reset();

        // Five frames from reset with no scroll.
        for (int i = 0; i < 5; i++) frame(1);
        check("x_after5", enemy1X, 405);
        check("dir_after5", enemyDir1, 0);

        // Pixel window at a scroll offset, taken straight after reset.
        do_reset();
        progress = 11'd300;
        pixel(100, 400);
        check("pix_in", enemy1, 1);
        pixel(116, 400);
        check("pix_right", enemy1, 0);
        pixel(100, 424);
        check("pix_below", enemy1, 0);

        // Patrol out to the right bound and back, character out of the way.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            progress = 11'($urandom_range(0, 400));
            frame(int'($urandom_range(1, 3)));
            if (m_wx == 560) check("turn_dir", enemyDir1, 1);
            pixel_near();
        end

        // Stomp on the top band, then watch the squash run out.
        progress = 11'd0;
        do_reset();
        characterX = 11'd402;
        characterY = 11'd380;
        frame(1);
        check("stomp_hit", m_stomp, 1);
        characterY = 11'd0;
        for (int i = 0; i < 30; i++) begin
            frame(1);
            pixel(405, 410);
        end
        check("gone", m_mode, 2);

        // Side hit kills; the enemy keeps walking; reset clears it.
        do_reset();
        characterX = 11'd402;
        characterY = 11'd400;
        frame(1);
        check("kill_dead", dead, 1);
        check("kill_moved", enemy1X, 401);
        characterY = 11'd0;
        do_reset();

        // Enemy scrolled off the left edge: no collision, no sprite.
        progress = 11'd500;
        characterX = 11'((400 - 500) & 2047);
        characterY = 11'd400;
        frame(1);
        check("off_dead", dead, 0);
        for (int i = 0; i < 4; i++) pixel(int'($urandom_range(0, 639)), int'($urandom_range(380, 430)));

        // Reset coinciding with a frame edge wins.
        progress = 11'd0;
        characterY = 11'd0;
        do_reset();
        frame(1);
        frame_clk = 1'b1;
        Reset = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
        Reset = 1'b0;
        model_reset();
        check("rst_over_fe", enemy1X, 400);

        // Random play: characters near the enemy, random scroll, occasional reset.
        for (int i = 0; i < 400; i++) begin
            progress = 11'($urandom_range(0, 600));
            if ($urandom_range(0, 2) == 0) begin
                characterX = 11'((model_sx() + int'($urandom_range(0, 40)) - 20) & 2047);
                characterY = 11'(400 + int'($urandom_range(0, 60)) - 30);
            end else begin
                characterX = 11'($urandom_range(0, 2047));
                characterY = 11'($urandom_range(0, 300));
            end
            frame(int'($urandom_range(1, 3)));
            pixel_near();
            pixel(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            if ((m_dead != 0 || m_mode == 2) && $urandom_range(0, 9) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
